// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
// An entry packs {PC, PC4, Inst} with PC in the most significant word.
package if_id_queue_pkg;

    localparam int unsigned ENTRY_W  = 96;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int unsigned INST_LSB = 0;
    localparam int unsigned INST_MSB = 31;
    localparam int unsigned PC4_LSB  = 32;
    localparam int unsigned PC4_MSB  = 63;
    localparam int unsigned PC_LSB   = 64;
    localparam int unsigned PC_MSB   = 95;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_PUSH_POP,
        OP_FLUSH
    } queue_op_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] pc4,
        input logic [31:0] inst
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[PC_MSB:PC_LSB]     = pc;
        e[PC4_MSB:PC4_LSB]   = pc4;
        e[INST_MSB:INST_LSB] = inst;
        return e;
    endfunction

endpackage

// File: rtl/if_id_queue_ram.sv
// Entry storage for the IF/ID queue: one synchronous write port, one
// asynchronous read port, contents deliberately not reset.
module if_id_queue_ram
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers fetched {PC, PC4, Inst} tuples in order,
// with valid/ready on both sides and a full flush on a MEM-stage redirect.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          MEM_PCSrc,
    input  logic          IFin_Valid,
    input  logic [31:0]   IFin_PC,
    input  logic [31:0]   IFin_PC4,
    input  logic [31:0]   IFin_Inst,
    output logic          IF_Ready,
    output logic          IDout_Valid,
    output logic [31:0]   IDout_PC,
    output logic [31:0]   IDout_PC4,
    output logic [31:0]   IDout_Inst,
    input  logic          ID_Ready,
    output logic [AW:0]   Q_Count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    queue_op_t          op;

    // Handshakes depend only on state and MEM_PCSrc, never on ID_Ready,
    // so a decode stall cannot form a combinational loop back into fetch.
    assign IF_Ready    = (Q_Count != FULL_COUNT) && !MEM_PCSrc;
    assign IDout_Valid = (Q_Count != '0) && !MEM_PCSrc;

    assign push = IFin_Valid && IF_Ready;
    assign pop  = IDout_Valid && ID_Ready;

    always_comb begin
        op = OP_IDLE;
        if (MEM_PCSrc) begin
            op = OP_FLUSH;
        end else begin
            unique case ({push, pop})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = OP_PUSH_POP;
                default: op = OP_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Q_Count <= '0;
        end else begin
            unique case (op)
                OP_FLUSH: begin
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    Q_Count <= '0;
                end
                OP_PUSH: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    Q_Count <= Q_Count + 1'b1;
                end
                OP_POP: begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    Q_Count <= Q_Count - 1'b1;
                end
                OP_PUSH_POP: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    if_id_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (Clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (pack_entry(IFin_PC, IFin_PC4, IFin_Inst)),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Storage is unreset; gating keeps stale or wrong-path words away from ID.
    assign IDout_PC   = IDout_Valid ? head[PC_MSB:PC_LSB]     : '0;
    assign IDout_PC4  = IDout_Valid ? head[PC4_MSB:PC4_LSB]   : '0;
    assign IDout_Inst = IDout_Valid ? head[INST_MSB:INST_LSB] : NOP_INST;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

    logic        Clk;
    logic        Clrn;
    logic        MEM_PCSrc;
    logic        IFin_Valid;
    logic [31:0] IFin_PC;
    logic [31:0] IFin_PC4;
    logic [31:0] IFin_Inst;
    logic        IF_Ready;
    logic        IDout_Valid;
    logic [31:0] IDout_PC;
    logic [31:0] IDout_PC4;
    logic [31:0] IDout_Inst;
    logic        ID_Ready;
    logic [2:0]  Q_Count;

    int unsigned n_checks;
    int unsigned n_fail;

    if_id_queue #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .MEM_PCSrc   (MEM_PCSrc),
        .IFin_Valid  (IFin_Valid),
        .IFin_PC     (IFin_PC),
        .IFin_PC4    (IFin_PC4),
        .IFin_Inst   (IFin_Inst),
        .IF_Ready    (IF_Ready),
        .IDout_Valid (IDout_Valid),
        .IDout_PC    (IDout_PC),
        .IDout_PC4   (IDout_PC4),
        .IDout_Inst  (IDout_Inst),
        .ID_Ready    (ID_Ready),
        .Q_Count     (Q_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Inst encodes the PC so order errors show up in every field.
    task automatic drive(input logic valid, input logic [31:0] pc);
        IFin_Valid = valid;
        IFin_PC    = pc;
        IFin_PC4   = pc + 32'd4;
        IFin_Inst  = 32'h1300_0000 | pc;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, IDout_Valid}, 32'd1);
        check({tag, "_pc"},    IDout_PC,   pc);
        check({tag, "_pc4"},   IDout_PC4,  pc + 32'd4);
        check({tag, "_inst"},  IDout_Inst, 32'h1300_0000 | pc);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, {29'd0, Q_Count}, 32'd0);
        check({tag, "_valid"}, {31'd0, IDout_Valid}, 32'd0);
        check({tag, "_inst"},  IDout_Inst, 32'd0);
        check({tag, "_pc"},    IDout_PC, 32'd0);
        check({tag, "_ifrdy"}, {31'd0, IF_Ready}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        Clrn       = 1'b0;
        MEM_PCSrc  = 1'b0;
        ID_Ready   = 1'b0;
        drive(1'b0, 32'd0);
        #2;
        check_empty("por");
        #10 Clrn = 1'b1;
        tick();

        // Order, one-cycle latency, no bypass
        drive(1'b1, 32'h0);
        IFin_Inst = 32'h2008_0001;
        #1;
        check("nobypass_valid", {31'd0, IDout_Valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, IDout_Valid}, 32'd1);
        check("lat_inst", IDout_Inst, 32'h2008_0001);
        drive(1'b1, 32'h4);
        IFin_Inst = 32'h2008_0002;
        tick();
        drive(1'b1, 32'h8);
        IFin_Inst = 32'h2008_0003;
        tick();
        drive(1'b0, 32'h0);
        check("order_count", {29'd0, Q_Count}, 32'd3);
        ID_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("order_pc",   IDout_PC,   32'(4 * i));
            check("order_pc4",  IDout_PC4,  32'(4 * i + 4));
            check("order_inst", IDout_Inst, 32'h2008_0001 + 32'(i));
            tick();
        end
        ID_Ready = 1'b0;
        check_empty("order_drained");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i));
            tick();
        end
        drive(1'b0, 32'h0);
        check("rst_pre_count", {29'd0, Q_Count}, 32'd3);
        Clrn = 1'b0;
        #1;
        check_empty("rst_async");
        #1 Clrn = 1'b1;
        tick();
        check_empty("rst_after");

        // Full: fifth tuple dropped, pop frees space next cycle only
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i));
            tick();
            check("full_fill_count", {29'd0, Q_Count}, 32'(i + 1));
        end
        check("full_ifrdy", {31'd0, IF_Ready}, 32'd0);
        drive(1'b1, 32'h200);
        tick();
        check("full_drop_count", {29'd0, Q_Count}, 32'd4);
        check_head("full_head", 32'h100);
        ID_Ready = 1'b1;
        #1;
        check("full_pop_ifrdy", {31'd0, IF_Ready}, 32'd0);
        tick();
        ID_Ready = 1'b0;
        drive(1'b0, 32'h0);
        check("full_after_count", {29'd0, Q_Count}, 32'd3);
        check("full_after_ifrdy", {31'd0, IF_Ready}, 32'd1);
        ID_Ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_head("full_drain", 32'h100 + 32'(4 * i));
            tick();
        end
        ID_Ready = 1'b0;
        check_empty("full_drained");

        // Steady push+pop at count 2 across pointer wrap
        drive(1'b1, 32'h300);
        tick();
        drive(1'b1, 32'h304);
        tick();
        ID_Ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h308 + 32'(4 * k));
            check_head("wrap_head", 32'h300 + 32'(4 * k));
            tick();
            check("wrap_count", {29'd0, Q_Count}, 32'd2);
        end
        drive(1'b0, 32'h0);
        check_head("wrap_tail0", 32'h328);
        tick();
        check_head("wrap_tail1", 32'h32C);
        tick();
        ID_Ready = 1'b0;
        check_empty("wrap_drained");

        // Flush with push and pop both requested
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i));
            tick();
        end
        check("flush_pre_count", {29'd0, Q_Count}, 32'd3);
        MEM_PCSrc = 1'b1;
        ID_Ready  = 1'b1;
        drive(1'b1, 32'h600);
        check("flush_valid", {31'd0, IDout_Valid}, 32'd0);
        check("flush_ifrdy", {31'd0, IF_Ready}, 32'd0);
        check("flush_inst",  IDout_Inst, 32'd0);
        check("flush_pc",    IDout_PC, 32'd0);
        tick();
        MEM_PCSrc = 1'b0;
        ID_Ready  = 1'b0;
        drive(1'b0, 32'h0);
        check_empty("flush_after");
        drive(1'b1, 32'h40);
        tick();
        drive(1'b0, 32'h0);
        check("flush_next_count", {29'd0, Q_Count}, 32'd1);
        check_head("flush_next", 32'h40);
        ID_Ready = 1'b1;
        tick();
        check_empty("flush_next_popped");

        // Push and pop request together on an empty queue
        drive(1'b1, 32'h80);
        check("emptypp_valid", {31'd0, IDout_Valid}, 32'd0);
        tick();
        drive(1'b0, 32'h0);
        check("emptypp_count", {29'd0, Q_Count}, 32'd1);
        check_head("emptypp_head", 32'h80);
        tick();
        ID_Ready = 1'b0;
        check_empty("emptypp_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
